pacman_motion_ctrl: RTL



---
 rtl/pacman_motion_ctrl_if.sv | 10 +
 rtl/pacman_motion_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pacman_motion_ctrl_if.sv
// rtl/pacman_motion_ctrl_if.sv - walkable-map read port between the motion controller (master) and the map ROM (slave)
interface pacman_motion_ctrl_if #(
    parameter int ADDR_WIDTH = 19
);
    logic [ADDR_WIDTH-1:0] map_addr;
    logic                  map_allowed;

    modport master (output map_addr, input map_allowed);
    modport slave  (input map_addr, output map_allowed);
endinterface

// File: rtl/pacman_motion_ctrl.sv
// rtl/pacman_motion_ctrl.sv - Pac-Man position/direction controller with debounced buttons and map edge checks; PACMAN_WRAP_TUNNEL_EN enables horizontal wrap
module pacman_motion_ctrl #(
    parameter int WIDTH           = 640,
    parameter int HEIGHT          = 480,
    parameter int SPRITE          = 22,
    parameter int START_X         = 310,
    parameter int START_Y         = 230,
    parameter int STEP            = 1,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ADDR_WIDTH      = 19
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic                 btn_up,
    input  logic                 btn_down,
    input  logic                 btn_left,
    input  logic                 btn_right,
    pacman_motion_ctrl_if.master map_bus,
    output logic [9:0]           pos_x,
    output logic [8:0]           pos_y,
    output logic [2:0]           dir,
    output logic                 busy,
    output logic                 moved,
    output logic                 blocked,
    output logic                 overrun
);

    localparam logic [2:0] DIR_NONE  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_DOWN  = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;
    localparam logic [2:0] DIR_RIGHT = 3'd4;

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CNT_W = $clog2(SPRITE + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHK_PEND,
        S_CHK_CUR,
        S_COMMIT
    } state_t;

    // ------------------------------------------------------------------
    // Button synchronizers and debouncers (bit i carries direction i+1)
    // ------------------------------------------------------------------
    logic [3:0]      btn_raw;
    logic [3:0]      sync0;
    logic [3:0]      sync1;
    logic [3:0]      btn_db;
    logic [3:0]      btn_rise;
    logic [DB_W-1:0] db_cnt [4];
    logic [2:0]      new_press;

    assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync0  <= '0;
            sync1  <= '0;
            btn_db <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync0 <= btn_raw;
            sync1 <= sync0;
            for (int i = 0; i < 4; i++) begin
                if (sync1[i] != btn_db[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        btn_db[i] <= sync1[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // A rising edge is the cycle in which the debounced level flips to pressed.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            btn_rise[i] = sync1[i] & ~btn_db[i] & (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1));
        end
        if (btn_rise[0])      new_press = DIR_UP;
        else if (btn_rise[1]) new_press = DIR_DOWN;
        else if (btn_rise[2]) new_press = DIR_LEFT;
        else if (btn_rise[3]) new_press = DIR_RIGHT;
        else                  new_press = DIR_NONE;
    end

    // ------------------------------------------------------------------
    // Geometry helpers
    // ------------------------------------------------------------------
    // Candidate leaves the legal top-left range; evaluated before any subtraction.
    function automatic logic edge_oob(input logic [2:0] d, input logic [9:0] px, input logic [8:0] py);
        case (d)
            DIR_UP:    return int'(py) < STEP;
            DIR_DOWN:  return int'(py) + STEP > HEIGHT - SPRITE;
            DIR_LEFT:  return int'(px) < STEP;
            DIR_RIGHT: return int'(px) + STEP > WIDTH - SPRITE;
            default:   return 1'b1;
        endcase
    endfunction

    // Address of the idx-th pixel on the new leading edge in direction d.
    function automatic logic [ADDR_WIDTH-1:0] edge_addr(input logic [2:0] d, input int idx,
                                                        input logic [9:0] px, input logic [8:0] py);
        int          cx;
        int          cy;
        logic [31:0] lin;
        cx = int'(px);
        cy = int'(py);
        case (d)
            DIR_UP: begin
                cx = cx + idx;
                cy = cy - STEP;
            end
            DIR_DOWN: begin
                cx = cx + idx;
                cy = cy + SPRITE - 1 + STEP;
            end
            DIR_LEFT: begin
                cx = cx - STEP;
                cy = cy + idx;
            end
            default: begin
                cx = cx + SPRITE - 1 + STEP;
                cy = cy + idx;
            end
        endcase
        lin = 32'(cx + WIDTH * cy);
        return lin[ADDR_WIDTH-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Motion FSM
    // ------------------------------------------------------------------
    state_t                state, state_n;
    logic [2:0]            cdir, cdir_n;
    logic [CNT_W-1:0]      iss_cnt, iss_cnt_n;
    logic [CNT_W-1:0]      smp_cnt, smp_cnt_n;
    logic [CNT_W-1:0]      n_reads;
    logic                  ok, ok_n;
    logic                  v1, v1_n;
    logic                  v2, v2_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [9:0]            pos_x_n;
    logic [8:0]            pos_y_n;
    logic [2:0]            dir_n;
    logic [2:0]            pending, pending_n;
    logic                  moved_n, blocked_n, overrun_n;
    logic                  cur_oob, cur_wrap, commit_wrap;
    logic                  chk_done, chk_pass;

    assign map_bus.map_addr = addr_q;
    assign busy             = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cdir    <= DIR_NONE;
            iss_cnt <= '0;
            smp_cnt <= '0;
            ok      <= 1'b1;
            v1      <= 1'b0;
            v2      <= 1'b0;
            addr_q  <= '0;
            pos_x   <= 10'(START_X);
            pos_y   <= 9'(START_Y);
            dir     <= DIR_NONE;
            pending <= DIR_NONE;
            moved   <= 1'b0;
            blocked <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_n;
            cdir    <= cdir_n;
            iss_cnt <= iss_cnt_n;
            smp_cnt <= smp_cnt_n;
            ok      <= ok_n;
            v1      <= v1_n;
            v2      <= v2_n;
            addr_q  <= addr_n;
            pos_x   <= pos_x_n;
            pos_y   <= pos_y_n;
            dir     <= dir_n;
            pending <= pending_n;
            moved   <= moved_n;
            blocked <= blocked_n;
            overrun <= overrun_n;
        end
    end

    always_comb begin
        state_n   = state;
        cdir_n    = cdir;
        iss_cnt_n = iss_cnt;
        smp_cnt_n = smp_cnt;
        ok_n      = ok;
        v1_n      = 1'b0;
        v2_n      = v1;
        addr_n    = addr_q;
        pos_x_n   = pos_x;
        pos_y_n   = pos_y;
        dir_n     = dir;
        pending_n = (new_press != DIR_NONE) ? new_press : pending;
        moved_n   = 1'b0;
        blocked_n = 1'b0;
        overrun_n = frame_tick && (state != S_IDLE);
        chk_done  = 1'b0;
        chk_pass  = 1'b0;
        cur_oob   = edge_oob(cdir, pos_x, pos_y);
`ifdef PACMAN_WRAP_TUNNEL_EN
        cur_wrap    = cur_oob && ((cdir == DIR_LEFT) || (cdir == DIR_RIGHT));
        commit_wrap = edge_oob(dir, pos_x, pos_y) && ((dir == DIR_LEFT) || (dir == DIR_RIGHT));
`else
        cur_wrap    = 1'b0;
        commit_wrap = 1'b0;
`endif
        // A wrap issues one dummy read so it costs the same as a one-read check.
        n_reads = cur_wrap ? CNT_W'(1) : CNT_W'(SPRITE);

        case (state)
            S_IDLE: begin
                iss_cnt_n = '0;
                smp_cnt_n = '0;
                ok_n      = 1'b1;
                v2_n      = 1'b0;
                if (frame_tick) begin
                    if ((pending != DIR_NONE) && (pending != dir)) begin
                        state_n = S_CHK_PEND;
                        cdir_n  = pending;
                    end else if (dir != DIR_NONE) begin
                        state_n = S_CHK_CUR;
                        cdir_n  = dir;
                    end
                end
            end

            S_CHK_PEND, S_CHK_CUR: begin
                if (cur_oob && !cur_wrap) begin
                    chk_done = 1'b1;
                end else begin
                    if (iss_cnt < n_reads) begin
                        addr_n    = edge_addr(cdir, int'(iss_cnt), pos_x, pos_y);
                        iss_cnt_n = iss_cnt + CNT_W'(1);
                        v1_n      = 1'b1;
                    end
                    // v2 marks the cycle in which map_allowed answers an address issued two edges ago.
                    if (v2) begin
                        ok_n      = ok & (cur_wrap | map_bus.map_allowed);
                        smp_cnt_n = smp_cnt + CNT_W'(1);
                        if (smp_cnt == n_reads - CNT_W'(1)) begin
                            chk_done = 1'b1;
                            chk_pass = ok_n;
                        end
                    end
                end

                if (chk_done) begin
                    iss_cnt_n = '0;
                    smp_cnt_n = '0;
                    ok_n      = 1'b1;
                    v1_n      = 1'b0;
                    v2_n      = 1'b0;
                    if (state == S_CHK_PEND) begin
                        if (chk_pass) begin
                            dir_n   = cdir;
                            state_n = S_COMMIT;
                            if (new_press == DIR_NONE) begin
                                pending_n = DIR_NONE;
                            end
                        end else if (dir != DIR_NONE) begin
                            // Fall back to the current direction; its first read goes out now.
                            state_n   = S_CHK_CUR;
                            cdir_n    = dir;
                            addr_n    = edge_addr(dir, 0, pos_x, pos_y);
                            iss_cnt_n = CNT_W'(1);
                            v1_n      = 1'b1;
                        end else begin
                            state_n   = S_IDLE;
                            blocked_n = 1'b1;
                        end
                    end else begin
                        if (chk_pass) begin
                            state_n = S_COMMIT;
                        end else begin
                            state_n   = S_IDLE;
                            blocked_n = 1'b1;
                        end
                    end
                end
            end

            S_COMMIT: begin
                state_n = S_IDLE;
                moved_n = 1'b1;
                case (dir)
                    DIR_UP:    pos_y_n = pos_y - 9'(STEP);
                    DIR_DOWN:  pos_y_n = pos_y + 9'(STEP);
                    DIR_LEFT:  pos_x_n = commit_wrap ? 10'(WIDTH - SPRITE) : pos_x - 10'(STEP);
                    DIR_RIGHT: pos_x_n = commit_wrap ? 10'd0 : pos_x + 10'(STEP);
                    default:   moved_n = 1'b0;
                endcase
            end

            default: state_n = S_IDLE;
        endcase
    end

endmodule
